// File: rtl/mmio_fifo_pkg.sv
// Shared types and constants for the MMIO write-payload FIFO.
// Status word layout and CSR addresses are consumed by the parent AFU.
package mmio_fifo_pkg;

  localparam int unsigned STATUS_CNT_W = 8;

  localparam logic [15:0] CSR_DATA_ADDR   = 16'h0020;
  localparam logic [15:0] CSR_STATUS_ADDR = 16'h0022;
  localparam logic [15:0] CSR_CLEAR_ADDR  = 16'h0024;

  function automatic int unsigned ptr_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

  typedef struct packed {
    logic                    overflow;
    logic                    underflow;
    logic                    almost_full;
    logic                    full;
    logic                    empty;
    logic [STATUS_CNT_W-1:0] count;
  } t_fifo_status;

endpackage

// File: rtl/mmio_fifo_if.sv
// Push/pop handshake, status and error-clear bundle between the FIFO and its user.
interface mmio_fifo_if
  import mmio_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 8
);
  localparam int unsigned CNT_W = ptr_w(DEPTH) + 1;

  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             rd_en;
  logic [WIDTH-1:0] rd_data;
  logic             empty;
  logic             full;
  logic             almost_full;
  logic [CNT_W-1:0] count;
  logic             overflow;
  logic             underflow;
  logic             clr_err;
  t_fifo_status     status;

  modport master (
    output wr_en, wr_data, rd_en, clr_err,
    input  rd_data, empty, full, almost_full, count, overflow, underflow, status
  );

  modport slave (
    input  wr_en, wr_data, rd_en, clr_err,
    output rd_data, empty, full, almost_full, count, overflow, underflow, status
  );

endinterface

// File: rtl/mmio_fifo_mem.sv
// DEPTH x WIDTH register array: synchronous write, asynchronous read, no reset.
module mmio_fifo_mem #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PTR_W = 3
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [PTR_W-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mmio_fifo.sv
// First-word-fall-through FIFO for MMIO write payloads with occupancy flags
// and sticky overflow/underflow errors cleared by a W1C strobe.
module mmio_fifo
  import mmio_fifo_pkg::*;
#(
  parameter int unsigned WIDTH     = 64,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned AF_THRESH = DEPTH - 2
) (
  input  logic        clk,
  input  logic        rst,
  mmio_fifo_if.slave  bus
);

  localparam int unsigned PTR_W = ptr_w(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr, wr_ptr_nxt;
  logic [PTR_W-1:0] rd_ptr, rd_ptr_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic             overflow, overflow_nxt;
  logic             underflow, underflow_nxt;
  logic             empty, full;
  logic             push_ok, pop_ok;
  logic [WIDTH-1:0] mem_rdata;

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));

  // Next-state: at full a simultaneous push/pop reuses the slot being vacated.
  always_comb begin
    wr_ptr_nxt    = wr_ptr;
    rd_ptr_nxt    = rd_ptr;
    count_nxt     = count;
    overflow_nxt  = overflow;
    underflow_nxt = underflow;

    push_ok = bus.wr_en && (!full || bus.rd_en);
    pop_ok  = bus.rd_en && !empty;

    if (push_ok) wr_ptr_nxt = wr_ptr + PTR_W'(1);
    if (pop_ok)  rd_ptr_nxt = rd_ptr + PTR_W'(1);

    case ({push_ok, pop_ok})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase

    // A new error event wins over a same-cycle clear.
    if (bus.clr_err) begin
      overflow_nxt  = 1'b0;
      underflow_nxt = 1'b0;
    end
    if (bus.wr_en && full && !bus.rd_en) overflow_nxt  = 1'b1;
    if (bus.rd_en && empty)              underflow_nxt = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wr_ptr    <= wr_ptr_nxt;
      rd_ptr    <= rd_ptr_nxt;
      count     <= count_nxt;
      overflow  <= overflow_nxt;
      underflow <= underflow_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) assert (count <= CNT_W'(DEPTH));
  end

  mmio_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_mem (
    .clk   (clk),
    .we    (push_ok && !rst),
    .waddr (wr_ptr),
    .wdata (bus.wr_data),
    .raddr (rd_ptr),
    .rdata (mem_rdata)
  );

  // Head word is masked to zero while empty so stale storage never leaks out.
  assign bus.rd_data     = empty ? '0 : mem_rdata;
  assign bus.empty       = empty;
  assign bus.full        = full;
  assign bus.almost_full = (count >= CNT_W'(AF_THRESH));
  assign bus.count       = count;
  assign bus.overflow    = overflow;
  assign bus.underflow   = underflow;

  always_comb begin
    bus.status             = '0;
    bus.status.overflow    = overflow;
    bus.status.underflow   = underflow;
    bus.status.almost_full = (count >= CNT_W'(AF_THRESH));
    bus.status.full        = full;
    bus.status.empty       = empty;
    bus.status.count       = STATUS_CNT_W'(count);
  end

endmodule
